counter_top_8bit: RTL and testbench

//  - Enable-gated 8-bit binary up-counter with carry-out, built as a ripple-enable cascade of 4-bit segments.
//  - Counts the clock cycles on which cin is high, wraps modulo 2^WIDTH and flags the wrap on cout.
//  - Top-level block of the counter chapter; cout chains into a further counter stage's cin.

---
 rtl/counter_top_8bit_if.sv | 18 +
 rtl/counter_top_8bit.sv | 58 +++++
 tb/tb_counter_top_8bit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_top_8bit_if.sv
// Counter bus interface: count enable in, count and carry out.
// Optional feature macro: COUNTER_TOP_SCLR_EN adds the synchronous clear signal sclr.
interface counter_top_8bit_if #(
  parameter int WIDTH = 8
);
  logic             cin;
  logic [WIDTH-1:0] q;
  logic             cout;
`ifdef COUNTER_TOP_SCLR_EN
  logic             sclr;

  modport master (output cin, output sclr, input q, input cout);
  modport slave  (input cin, input sclr, output q, output cout);
`else
  modport master (output cin, input q, input cout);
  modport slave  (input cin, output q, output cout);
`endif
endinterface

// File: rtl/counter_top_8bit.sv
// Enable-gated up-counter built as a ripple-enable cascade of SEG_WIDTH segments.
// Each segment advances only when cin is high and every lower segment is all ones,
// which gives the same result as a flat WIDTH-bit increment.
// Optional feature macro: COUNTER_TOP_SCLR_EN adds synchronous clear sclr (priority over cin).
module counter_top_8bit #(
  parameter int WIDTH     = 8,
  parameter int SEG_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_top_8bit_if.slave  io_cnt
);

  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam logic [SEG_WIDTH-1:0] SEG_ONE = {{(SEG_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [NSEG-1:0]  w_seg_en;
  logic             w_clr;

`ifdef COUNTER_TOP_SCLR_EN
  assign w_clr = io_cnt.sclr;
`else
  assign w_clr = 1'b0;
`endif

  // Ripple the enable up through the segments and build the incremented value.
  always_comb begin
    logic w_en;
    w_q_next = r_q;
    w_seg_en = '0;
    w_en     = io_cnt.cin;
    for (int k = 0; k < NSEG; k++) begin
      w_seg_en[k] = w_en;
      if (w_en) begin
        w_q_next[k*SEG_WIDTH +: SEG_WIDTH] = r_q[k*SEG_WIDTH +: SEG_WIDTH] + SEG_ONE;
      end
      w_en = w_en & (&r_q[k*SEG_WIDTH +: SEG_WIDTH]);
    end
  end

  // Count register: async reset, then clear, then enabled segment updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (w_clr) begin
      r_q <= '0;
    end else if (w_seg_en[0]) begin
      r_q <= w_q_next;
    end
  end

  assign io_cnt.q    = r_q;
  // Carry out is combinational so a following stage sees it in the same cycle as cin.
  assign io_cnt.cout = io_cnt.cin & ~w_clr & (&r_q);

endmodule

// File: tb/tb_counter_top_8bit.sv
// Self-checking bench for counter_top_8bit against an integer reference model.
module tb_counter_top_8bit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   model_q;

  counter_top_8bit_if #(.WIDTH(8)) bus ();

  counter_top_8bit #(.WIDTH(8), .SEG_WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_cnt (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Drive inputs after the falling edge and settle before sampling.
  task automatic setup_cycle(input logic c, input logic s);
    @(negedge clk);
    bus.cin = c;
`ifdef COUNTER_TOP_SCLR_EN
    bus.sclr = s;
`else
    if (s) ; // clear not available in this build
`endif
    #1;
  endtask

  // Take the rising edge and advance the reference model.
  task automatic advance(input logic s);
    @(posedge clk);
    if (rst) model_q = 0;
    else if (s) model_q = 0;
    else if (bus.cin) model_q = (model_q + 1) % 256;
  endtask

  function automatic logic exp_cout(input logic c, input logic s, input int mq);
    return c && !s && (mq == 255);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'd0) begin
      failures++; $display("FAIL reset_immediate: q=%0d required 0", bus.q);
    end
    for (int i = 0; i < 6; i++) begin
      setup_cycle(i[0], 1'b0);
      checks++;
      if (bus.q !== 8'd0 || bus.cout !== 1'b0) begin
        failures++; $display("FAIL reset_hold: q=%0d cout=%0b required q=0 cout=0", bus.q, bus.cout);
      end
      advance(1'b0);
    end
    @(negedge clk);
    bus.cin = 1'b0;
    rst = 1'b0;
    model_q = 0;
    for (int i = 0; i < 4; i++) begin
      setup_cycle(1'b0, 1'b0);
      checks++;
      if (bus.q !== 8'd0 || bus.cout !== 1'b0) begin
        failures++; $display("FAIL reset_release: q=%0d cout=%0b required q=0 cout=0", bus.q, bus.cout);
      end
      advance(1'b0);
    end
  endtask

  task automatic test_pulse_count();
    for (int p = 1; p <= 300; p++) begin
      for (int i = 0; i < 5; i++) begin
        setup_cycle(1'b0, 1'b0);
        checks++;
        if (bus.q !== 8'(model_q) || bus.cout !== 1'b0) begin
          failures++; $display("FAIL pulse_idle: q=%0d cout=%0b required q=%0d cout=0", bus.q, bus.cout, model_q);
        end
        advance(1'b0);
      end
      setup_cycle(1'b1, 1'b0);
      checks++;
      if (bus.q !== 8'(model_q) || bus.cout !== exp_cout(1'b1, 1'b0, model_q)) begin
        failures++; $display("FAIL pulse_active: pulse=%0d q=%0d cout=%0b required q=%0d cout=%0b",
                             p, bus.q, bus.cout, model_q, exp_cout(1'b1, 1'b0, model_q));
      end
      if (p == 256) begin
        checks++;
        if (bus.cout !== 1'b1) begin
          failures++; $display("FAIL pulse_wrap_cout: cout=%0b required 1", bus.cout);
        end
      end
      advance(1'b0);
      if (p == 255 || p == 256 || p == 300) begin
        #1;
        checks++;
        if (bus.q !== ((p == 255) ? 8'd255 : (p == 256) ? 8'd0 : 8'd44)) begin
          failures++; $display("FAIL pulse_milestone: after pulse %0d q=%0d", p, bus.q);
        end
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 200; i++) begin
      setup_cycle(1'b0, 1'b0);
      checks++;
      if (bus.q !== 8'd44 || bus.cout !== 1'b0) begin
        failures++; $display("FAIL hold: q=%0d cout=%0b required q=44 cout=0", bus.q, bus.cout);
      end
      advance(1'b0);
    end
  endtask

  task automatic test_continuous();
    int          cout_cycles[$];
    logic [3:0]  prev_lo;
    logic [3:0]  prev_hi;
    @(negedge clk);
    rst = 1'b1;
    bus.cin = 1'b0;
    #2;
    rst = 1'b0;
    model_q = 0;
    for (int c = 0; c < 520; c++) begin
      setup_cycle(1'b1, 1'b0);
      checks++;
      if (bus.q !== 8'(c % 256)) begin
        failures++; $display("FAIL cont_q: cycle=%0d q=%0d required %0d", c, bus.q, c % 256);
      end
      if (c > 0) begin
        checks++;
        if (bus.q[7:4] !== 4'(prev_hi + ((prev_lo == 4'hF) ? 4'd1 : 4'd0))) begin
          failures++; $display("FAIL cont_seg1: cycle=%0d hi=%0d required %0d", c, bus.q[7:4],
                               4'(prev_hi + ((prev_lo == 4'hF) ? 4'd1 : 4'd0)));
        end
      end
      if (bus.cout === 1'b1) cout_cycles.push_back(c);
      prev_lo = bus.q[3:0];
      prev_hi = bus.q[7:4];
      advance(1'b0);
    end
    checks++;
    if (cout_cycles.size() != 2 || cout_cycles[0] != 255 || cout_cycles[1] != 511) begin
      failures++; $display("FAIL cont_cout_cycles: count=%0d required cycles 255 and 511", cout_cycles.size());
    end
    setup_cycle(1'b0, 1'b0);
    checks++;
    if (bus.q !== 8'd8) begin
      failures++; $display("FAIL cont_end: q=%0d required 8", bus.q);
    end
  endtask

  task automatic test_async_reset();
    while (model_q != 127) begin
      setup_cycle(1'b1, 1'b0);
      advance(1'b0);
    end
    setup_cycle(1'b0, 1'b0);
    checks++;
    if (bus.q !== 8'h7F) begin
      failures++; $display("FAIL async_pre: q=%0d required 127", bus.q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'd0) begin
      failures++; $display("FAIL async_immediate: q=%0d required 0", bus.q);
    end
    advance(1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.cin = 1'b1;
    advance(1'b0);
    #1;
    checks++;
    if (bus.q !== 8'd1) begin
      failures++; $display("FAIL async_resume: q=%0d required 1", bus.q);
    end
  endtask

  task automatic test_random();
    logic c;
    logic s;
    for (int i = 0; i < 600; i++) begin
      c = 1'($urandom_range(0, 3) != 0);
`ifdef COUNTER_TOP_SCLR_EN
      s = 1'($urandom_range(0, 31) == 0);
`else
      s = 1'b0;
`endif
      setup_cycle(c, s);
      checks++;
      if (bus.q !== 8'(model_q) || bus.cout !== exp_cout(c, s, model_q)) begin
        failures++; $display("FAIL random: step=%0d q=%0d cout=%0b required q=%0d cout=%0b",
                             i, bus.q, bus.cout, model_q, exp_cout(c, s, model_q));
      end
      advance(s);
    end
  endtask

`ifdef COUNTER_TOP_SCLR_EN
  task automatic test_sclr();
    while (model_q != 255) begin
      setup_cycle(1'b1, 1'b0);
      advance(1'b0);
    end
    setup_cycle(1'b1, 1'b1);
    checks++;
    if (bus.q !== 8'd255 || bus.cout !== 1'b0) begin
      failures++; $display("FAIL sclr_cout: q=%0d cout=%0b required q=255 cout=0", bus.q, bus.cout);
    end
    advance(1'b1);
    #1;
    checks++;
    if (bus.q !== 8'd0) begin
      failures++; $display("FAIL sclr_clear: q=%0d required 0", bus.q);
    end
    setup_cycle(1'b0, 1'b0);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    model_q  = 0;
    bus.cin  = 1'b0;
`ifdef COUNTER_TOP_SCLR_EN
    bus.sclr = 1'b0;
`endif
    rst = 1'b0;
    test_reset();
    test_pulse_count();
    test_hold();
    test_continuous();
    test_async_reset();
    test_random();
`ifdef COUNTER_TOP_SCLR_EN
    test_sclr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
